// File: rtl/seq_2bit_packer_if.sv
// Bus bundle for the 2-bit base packer: job control, source RAM read port,
// destination RAM write port and the per-job statistics.
interface seq_2bit_packer_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] seq_len;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] src_addr;
  logic                  src_en;
  logic [7:0]            src_data;
  logic [ADDR_WIDTH-1:0] dst_addr;
  logic [7:0]            dst_data;
  logic                  dst_we;
  logic [ADDR_WIDTH-1:0] base_count;
  logic [ADDR_WIDTH-1:0] gc_count;
  logic [ADDR_WIDTH-1:0] n_count;

  // The packer drives everything except the job request and the RAM read data.
  modport master (
    input  start, seq_len, src_data,
    output busy, done, src_addr, src_en, dst_addr, dst_data, dst_we,
           base_count, gc_count, n_count
  );

  modport slave (
    output start, seq_len, src_data,
    input  busy, done, src_addr, src_en, dst_addr, dst_data, dst_we,
           base_count, gc_count, n_count
  );
endinterface

// File: rtl/seq_2bit_packer.sv
// Reads ASCII bases from the converter RAM, encodes each as 2 bits, packs four
// bases per byte into a destination RAM and counts bases, GC and N/invalid bytes.
module seq_2bit_packer #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  seq_2bit_packer_if.master  bus
);

  typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] len_q;
  logic [7:0]            shreg_q;
  logic                  vld_p1;

  logic [3:0]            enc;
  logic [1:0]            slot;
  logic [7:0]            packed_next;
  logic                  last_base;

  // Returns {is_n, is_gc, code[1:0]} for one ASCII byte.
  function automatic logic [3:0] encode_base(input logic [7:0] b);
    case (b)
      8'h41, 8'h61: encode_base = 4'b0000;
      8'h43, 8'h63: encode_base = 4'b0101;
      8'h47, 8'h67: encode_base = 4'b0110;
      8'h54, 8'h74: encode_base = 4'b0011;
      default:      encode_base = 4'b1000;
    endcase
  endfunction

  // Inserts a 2-bit code at the given base slot of a partially packed byte.
  function automatic logic [7:0] pack_slot(input logic [7:0] acc,
                                           input logic [1:0] code,
                                           input logic [1:0] s);
    logic [7:0] r;
    r = acc;
    case (s)
      2'd0:    r[1:0] = code;
      2'd1:    r[3:2] = code;
      2'd2:    r[5:4] = code;
      default: r[7:6] = code;
    endcase
    return r;
  endfunction

  // Decode of the byte returned by the source RAM this cycle.
  always_comb begin
    enc         = encode_base(bus.src_data);
    slot        = bus.base_count[1:0];
    packed_next = pack_slot(shreg_q, enc[1:0], slot);
    last_base   = (bus.base_count == (len_q - ADDR_WIDTH'(1)));
  end

  // Job FSM: issues reads, samples one base per cycle, writes packed bytes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      len_q          <= '0;
      shreg_q        <= '0;
      vld_p1         <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.src_addr   <= '0;
      bus.src_en     <= 1'b0;
      bus.dst_addr   <= '0;
      bus.dst_data   <= '0;
      bus.dst_we     <= 1'b0;
      bus.base_count <= '0;
      bus.gc_count   <= '0;
      bus.n_count    <= '0;
    end else begin
      bus.done   <= 1'b0;
      bus.dst_we <= 1'b0;
      if (bus.dst_we) bus.dst_addr <= bus.dst_addr + ADDR_WIDTH'(1);

      case (state_q)
        IDLE: begin
          if (bus.start) begin
            bus.busy       <= 1'b1;
            bus.base_count <= '0;
            bus.gc_count   <= '0;
            bus.n_count    <= '0;
            bus.dst_addr   <= '0;
            shreg_q        <= '0;
            vld_p1         <= 1'b0;
            if (bus.seq_len != '0) begin
              len_q        <= bus.seq_len;
              bus.src_addr <= '0;
              bus.src_en   <= 1'b1;
              state_q      <= READ;
            end else begin
              bus.done <= 1'b1;
              state_q  <= DONE;
            end
          end
        end

        READ: begin
          // ---- stage p0: address issue; p1: RAM data returned and sampled ----
          vld_p1 <= bus.src_en;
          if (bus.src_en) begin
            if (bus.src_addr == (len_q - ADDR_WIDTH'(1))) bus.src_en <= 1'b0;
            else bus.src_addr <= bus.src_addr + ADDR_WIDTH'(1);
          end
          if (vld_p1) begin
            bus.base_count <= bus.base_count + ADDR_WIDTH'(1);
            bus.gc_count   <= bus.gc_count + ADDR_WIDTH'(enc[2]);
            bus.n_count    <= bus.n_count + ADDR_WIDTH'(enc[3]);
            // A full group or the final partial group is written next cycle;
            // unused upper slots of a partial byte are still zero.
            if (slot == 2'd3 || last_base) begin
              bus.dst_we   <= 1'b1;
              bus.dst_data <= packed_next;
              shreg_q      <= '0;
            end else begin
              shreg_q <= packed_next;
            end
            if (last_base) begin
              vld_p1  <= 1'b0;
              state_q <= FLUSH;
            end
          end
        end

        FLUSH: begin
          bus.done <= 1'b1;
          state_q  <= DONE;
        end

        default: begin
          bus.busy <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_2bit_packer.sv
module tb_seq_2bit_packer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seq_2bit_packer_if #(.ADDR_WIDTH(16)) bus();
  seq_2bit_packer #(.ADDR_WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] src_mem [0:255];
  always @(posedge clk) if (bus.src_en) bus.src_data <= src_mem[bus.src_addr[7:0]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int rel; int addr; int data; } wr_t;
  typedef struct { int rel; int base; int gc; int n; } dn_t;
  wr_t wq[$];
  dn_t dq[$];
  wr_t w;
  dn_t d;

  int n_total = 0;
  int n_pass  = 0;
  int start_cyc = 0;
  int cur_len = 0;
  int done_cnt = 0;
  int mon_rel;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_w(input int rel, input int addr, input int data);
    wr_t e;
    e.rel = rel; e.addr = addr; e.data = data;
    wq.push_back(e);
  endtask

  task automatic push_d(input int rel, input int base, input int gc, input int n);
    dn_t e;
    e.rel = rel; e.base = base; e.gc = gc; e.n = n;
    dq.push_back(e);
  endtask

  task automatic load(input string s);
    for (int i = 0; i < s.len(); i++) src_mem[i] = s[i];
  endtask

  // Monitor: pops expectations whenever the DUT writes or finishes.
  always @(negedge clk) begin
    if (rst) begin
      mon_rel = cyc - start_cyc;
      if (bus.src_en && (int'(bus.src_addr) >= cur_len))
        check("src_addr_bound", bus.src_addr, cur_len - 1);
      if (bus.dst_we) begin
        if (wq.size() == 0) check("unexpected_write", bus.dst_data, -1);
        else begin
          w = wq.pop_front();
          check("wr_cycle", mon_rel, w.rel);
          check("wr_addr", bus.dst_addr, w.addr);
          check("wr_data", bus.dst_data, w.data);
        end
      end
      if (bus.done) begin
        done_cnt++;
        check("done_busy", bus.busy, 1);
        if (dq.size() == 0) check("unexpected_done", 1, 0);
        else begin
          d = dq.pop_front();
          check("done_cycle", mon_rel, d.rel);
          check("base_count", bus.base_count, d.base);
          check("gc_count", bus.gc_count, d.gc);
          check("n_count", bus.n_count, d.n);
        end
      end
    end
  end

  task automatic run_job(input int len, input bit inj);
    int d0;
    int rel;
    cur_len = len;
    bus.seq_len = 16'(len);
    @(negedge clk);
    bus.start = 1'b1;
    start_cyc = cyc;
    d0 = done_cnt;
    for (int i = 0; i < len + 6; i++) begin
      @(negedge clk);
      rel = cyc - start_cyc;
      bus.start = inj && (rel == 4 || rel == len + 3);
      if (inj) bus.seq_len = 16'd3;
    end
    bus.start = 1'b0;
    check("one_done", done_cnt, d0 + 1);
    check("busy_after", bus.busy, 0);
    check("final_dst_addr", bus.dst_addr, (len + 3) / 4);
    check("src_en_after", bus.src_en, 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_src_en"}, bus.src_en, 0);
    check({tag, "_dst_we"}, bus.dst_we, 0);
    check({tag, "_dst_addr"}, bus.dst_addr, 0);
    check({tag, "_base"}, bus.base_count, 0);
    check({tag, "_gc"}, bus.gc_count, 0);
    check({tag, "_n"}, bus.n_count, 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.seq_len = '0;
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk) rst = 1'b1;

    load("ACGT");      push_w(6, 0, 'hE4); push_d(7, 4, 2, 0);
    run_job(4, 0);
    load("ACGTA");     push_w(6, 0, 'hE4); push_w(7, 1, 'h00); push_d(8, 5, 2, 0);
    run_job(5, 0);
    load("acgN");      push_w(6, 0, 'h24); push_d(7, 4, 2, 1);
    run_job(4, 0);
    push_d(1, 0, 0, 0);
    run_job(0, 0);
    load("GGGGCCCCT"); push_w(6, 0, 'hAA); push_w(10, 1, 'h55); push_w(11, 2, 'h03);
    push_d(12, 9, 8, 0);
    run_job(9, 0);
    load("TTTTAAAA");  push_w(6, 0, 'hFF); push_w(10, 1, 'h00); push_d(11, 8, 0, 0);
    run_job(8, 1);

    // Reset in the middle of a job, before any write is due.
    load("ACGTACGT");
    cur_len = 8;
    bus.seq_len = 16'd8;
    @(negedge clk);
    bus.start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 check_zero("midreset");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    load("ACGT");      push_w(6, 0, 'hE4); push_d(7, 4, 2, 0);
    run_job(4, 0);

    check("pending_writes", wq.size(), 0);
    check("pending_dones", dq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
